// File: rtl/inst_fetch_pkg.sv
// Shared constants and helpers for the instruction-fetch stage and its ROM
// bus interface.
package inst_fetch_pkg;

  localparam int PC_WIDTH   = 32;
  localparam int ROM_AW     = 6;
  localparam int INST_WIDTH = 32;

  localparam logic [PC_WIDTH-1:0]   RESET_PC = 32'h0000_0000;
  localparam logic [INST_WIDTH-1:0] NOP_INST = 32'h0000_0000;
  localparam logic [PC_WIDTH-1:0]   PC_INC   = 32'd4;

  // Byte PC to ROM word index; the shift-and-truncate makes the index wrap
  // every 2^ROM_AW words.
  function automatic logic [ROM_AW-1:0] pc_to_word_addr(input logic [PC_WIDTH-1:0] pc);
    return ROM_AW'(pc >> 2);
  endfunction

endpackage

// File: rtl/inst_fetch_if.sv
// ROM access bus between the fetch stage (master) and the instruction ROM
// (slave).
interface inst_fetch_if;
  import inst_fetch_pkg::*;

  logic                  rom_ce;
  logic [ROM_AW-1:0]     rom_addr;
  logic [INST_WIDTH-1:0] rom_inst;

  modport master (output rom_ce, output rom_addr, input rom_inst);
  modport slave  (input rom_ce, input rom_addr, output rom_inst);

endinterface

// File: rtl/inst_fetch_pc_reg.sv
// Program counter and ROM enable: reset, sequential increment, stall hold
// and branch redirect.
module inst_fetch_pc_reg
  import inst_fetch_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                stall,
  input  logic                branch_flag,
  input  logic [PC_WIDTH-1:0] branch_target,
  output logic [PC_WIDTH-1:0] pc,
  output logic                rom_ce
);

  localparam logic [PC_WIDTH-1:0] ALIGN_MASK = {{(PC_WIDTH-2){1'b1}}, 2'b00};

  logic [PC_WIDTH-1:0] pc_d, pc_q;
  logic                ce_d, ce_q;

  always_comb begin
    pc_d = pc_q;
    ce_d = ce_q;
    // The first cycle out of reset only enables the ROM, so RESET_PC is
    // the first address actually fetched.
    if (!ce_q) begin
      ce_d = 1'b1;
    end else if (stall) begin
      pc_d = pc_q;
    end else if (branch_flag) begin
      pc_d = branch_target & ALIGN_MASK;
    end else begin
      pc_d = pc_q + PC_INC;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
      ce_q <= 1'b0;
    end else begin
      pc_q <= pc_d;
      ce_q <= ce_d;
    end
  end

  assign pc     = pc_q;
  assign rom_ce = ce_q;

endmodule

// File: rtl/inst_fetch.sv
// Instruction-fetch stage: drives the instruction ROM and captures its output
// into the IF/ID register, with stall and single-bubble branch squash.
module inst_fetch
  import inst_fetch_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stall,
  input  logic                  branch_flag,
  input  logic [PC_WIDTH-1:0]   branch_target,
  inst_fetch_if.master          rom,
  output logic [PC_WIDTH-1:0]   if_pc,
  output logic [PC_WIDTH-1:0]   id_pc,
  output logic [INST_WIDTH-1:0] id_inst,
  output logic                  id_valid
);

  logic [PC_WIDTH-1:0] pc;
  logic                rom_ce;

  inst_fetch_pc_reg u_pc_reg (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall         (stall),
    .branch_flag   (branch_flag),
    .branch_target (branch_target),
    .pc            (pc),
    .rom_ce        (rom_ce)
  );

  assign rom.rom_ce   = rom_ce;
  assign rom.rom_addr = pc_to_word_addr(pc);
  assign if_pc        = pc;

  // ---- IF -> ID boundary ----
  logic [PC_WIDTH-1:0]   id_pc_d, id_pc_q;
  logic [INST_WIDTH-1:0] id_inst_d, id_inst_q;
  logic                  id_valid_d, id_valid_q;

  always_comb begin
    id_pc_d    = id_pc_q;
    id_inst_d  = id_inst_q;
    id_valid_d = id_valid_q;
    if (!rom_ce) begin
      id_pc_d    = '0;
      id_inst_d  = NOP_INST;
      id_valid_d = 1'b0;
    end else if (stall) begin
      id_valid_d = id_valid_q;
    end else if (branch_flag) begin
      // The word fetched this cycle is on the wrong path; replace it.
      id_pc_d    = '0;
      id_inst_d  = NOP_INST;
      id_valid_d = 1'b0;
    end else begin
      id_pc_d    = pc;
      id_inst_d  = rom.rom_inst;
      id_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      id_pc_q    <= '0;
      id_inst_q  <= NOP_INST;
      id_valid_q <= 1'b0;
    end else begin
      id_pc_q    <= id_pc_d;
      id_inst_q  <= id_inst_d;
      id_valid_q <= id_valid_d;
    end
  end

  assign id_pc    = id_pc_q;
  assign id_inst  = id_inst_q;
  assign id_valid = id_valid_q;

endmodule
